serial_word_loader: RTL and testbench
=====================================

// Module: serial_word_loader
//
// PURPOSE
//   Assembles a framed serial bit stream (sensor/config link) into WIDTH-bit
//   words and issues a one-cycle write strobe to the downstream 32-bit
//   register bank. word/wrenable connect directly to the register's d/wrenable.
//   Sits between the serial front end and the holding registers.
//
// PARAMETERS
//   WIDTH      32  bits per word; also the register width fed downstream
//   MSB_FIRST  1   1: first bit received lands in word[WIDTH-1]; 0: in word[0]
//
// PORTS
//   clk        in   1      single system clock; all logic on posedge
//   reset_n    in   1      synchronous, active-low reset
//   frame      in   1      high = transfer in progress; low = idle/abort
//   bit_valid  in   1      bit_in is sampled this cycle (gaps allowed)
//   bit_in     in   1      serial data bit
//   word       out  WIDTH  last completed word; held between commits
//   wrenable   out  1      one-cycle pulse: word is new, write it downstream
//   frame_err  out  1      one-cycle pulse: frame dropped mid-word
//   busy       out  1      high while in SHIFT state
//   bit_count  out  clog2(WIDTH)  bits accepted into current partial word
//
// BEHAVIOUR
//   - Reset (reset_n=0 at posedge): state=IDLE; word=0, wrenable=0,
//     frame_err=0, busy=0, bit_count=0, shift register=0. Reset mid-word
//     discards the partial word; no wrenable, no frame_err.
//   - A bit is accepted only when frame=1 and bit_valid=1 (any state).
//     bit_valid with frame=0 is ignored.
//   - IDLE: frame=1 -> SHIFT. A bit accepted in that same cycle counts as bit 0.
//   - SHIFT: each accepted bit shifts in (MSB_FIRST=1: shift left, insert at
//     LSB; 0: shift right, insert at MSB); bit_count increments.
//   - Word complete: on acceptance of the WIDTH-th bit, bit_count -> 0 and,
//     at the next posedge edge output, word <= assembled value, wrenable=1 for
//     exactly one cycle (latency 1 cycle after last bit sampled).
//   - Back-to-back: state stays SHIFT while frame=1; a bit in the wrenable
//     cycle is bit 0 of the next word. No dead cycles; sustained rate 1 bit/cycle.
//   - frame falls (frame=0 in SHIFT): -> IDLE. If bit_count!=0, frame_err=1
//     for one cycle, partial word discarded, word unchanged, no wrenable.
//     If bit_count==0 (word boundary), clean end, no error.
//   - frame=0 in the cycle of the would-be WIDTH-th bit: bit not accepted,
//     treated as abort (frame_err).
//   - wrenable and frame_err are never asserted in the same cycle.
//   - busy = (state==SHIFT). bit_count wraps WIDTH-1 -> 0 only via commit.
//
// TESTING
//   1. MSB_FIRST=1, frame=1, 32 bits of 0xA5C30F17 every cycle -> one
//      wrenable pulse 1 cycle after bit 32, word=0xA5C30F17, frame_err=0.
//   2. One frame, 64 consecutive bits 0x00000001 then 0xFFFFFFFF -> two
//      wrenable pulses exactly 32 cycles apart with those word values.
//   3. 17 bits then frame=0 -> frame_err pulse 1 cycle, no wrenable, word
//      holds previous value, busy=0, bit_count=0.
//   4. bit_valid toggling with frame=0 for 40 cycles -> no state change,
//      bit_count=0, no pulses; random bit_valid gaps inside a frame still
//      yield correct word 0x5A5A5A5A.
//   5. reset_n=0 for 1 cycle after 10 bits -> all outputs 0; following full
//      word 0xDEADBEEF loads correctly with single wrenable.
//   6. MSB_FIRST=0, LSB-first stream of 0x12345678 -> word=0x12345678.

Source files
------------

// File: rtl/serial_word_loader.sv
// serial_word_loader: deserialises a framed bit stream into WIDTH-bit words.
// It issues a one-cycle wrenable each time a word completes. A frame that
// drops in the middle of a word produces a one-cycle frame_err pulse.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no transfer; bit_count is 0 and the shift register is clear
// SHIFT  | frame asserted; accepted bits are assembling into a word
module serial_word_loader #(
    parameter int WIDTH     = 32,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     frame,
    input  logic                     bit_valid,
    input  logic                     bit_in,
    output logic [WIDTH-1:0]         word,
    output logic                     wrenable,
    output logic                     frame_err,
    output logic                     busy,
    output logic [$clog2(WIDTH)-1:0] bit_count
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             wren_q, wren_d;
    logic             ferr_q, ferr_d;
    logic [WIDTH-1:0] sr_shifted;

    // Shift direction is fixed by MSB_FIRST: the first bit ends up in
    // word[WIDTH-1] (shift left) or in word[0] (shift right).
    always_comb begin
        if (MSB_FIRST) begin
            sr_shifted = {sr_q[WIDTH-2:0], bit_in};
        end else begin
            sr_shifted = {bit_in, sr_q[WIDTH-1:1]};
        end
    end

    // Next-state logic. A bit is taken only while frame is high, in either
    // state. This lets the cycle that leaves IDLE also carry bit 0.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        wren_d  = 1'b0;
        ferr_d  = 1'b0;
        if (frame) begin
            state_d = ST_SHIFT;
            if (bit_valid) begin
                if (cnt_q == LAST_BIT) begin
                    word_d = sr_shifted;
                    wren_d = 1'b1;
                    cnt_d  = '0;
                    sr_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    sr_d  = sr_shifted;
                end
            end
        end else begin
            // Frame low: any partial word is dropped. The drop is flagged
            // only when the frame ends off a word boundary.
            if (state_q == ST_SHIFT && cnt_q != '0) begin
                ferr_d = 1'b1;
            end
            state_d = ST_IDLE;
            cnt_d   = '0;
            sr_d    = '0;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            wren_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            wren_q  <= wren_d;
            ferr_q  <= ferr_d;
        end
    end

    assign word      = word_q;
    assign wrenable  = wren_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q == ST_SHIFT);
    assign bit_count = cnt_q;

endmodule

// File: tb/tb_serial_word_loader.sv
// Directed bench for serial_word_loader. Sent words are queued as expected
// results. A negedge monitor pops the queue on every wrenable and compares.
module tb_serial_word_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        f0, v0, b0, f1, v1, b1;
    logic [31:0] word0, word1;
    logic        wren0, ferr0, busy0, wren1, ferr1, busy1;
    logic [4:0]  cnt0, cnt1;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          wren_cnt0 = 0, ferr_cnt0 = 0, wren_cnt1 = 0;
    int          last_wren_cyc = 0, prev_wren_cyc = 0;
    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];

    serial_word_loader #(.WIDTH(32), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .reset_n(rst_n), .frame(f0), .bit_valid(v0), .bit_in(b0),
        .word(word0), .wrenable(wren0), .frame_err(ferr0), .busy(busy0),
        .bit_count(cnt0)
    );

    serial_word_loader #(.WIDTH(32), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset_n(rst_n), .frame(f1), .bit_valid(v1), .bit_in(b1),
        .word(word1), .wrenable(wren1), .frame_err(ferr1), .busy(busy1),
        .bit_count(cnt1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitors, sampling mid-cycle.
    always @(negedge clk) begin
        if (wren0 || ferr0) check("excl0", 32'(wren0 & ferr0), 32'h0);
        if (ferr0) ferr_cnt0++;
        if (wren0) begin
            wren_cnt0++;
            prev_wren_cyc = last_wren_cyc;
            last_wren_cyc = cyc;
            if (exp_q0.size() == 0) check("unexpected_wren0", 32'h1, 32'h0);
            else check("word0", word0, exp_q0.pop_front());
        end
        if (wren1) begin
            wren_cnt1++;
            if (exp_q1.size() == 0) check("unexpected_wren1", 32'h1, 32'h0);
            else check("word1", word1, exp_q1.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits0(input logic [31:0] w, input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 2) == 0) begin
                    f0 = 1'b1; v0 = 1'b0; b0 = $urandom_range(0, 1) != 0;
                    step();
                end
            end
            f0 = 1'b1; v0 = 1'b1; b0 = w[31-i];
            step();
        end
        v0 = 1'b0;
    endtask

    task automatic send_word0(input logic [31:0] w, input bit gaps);
        exp_q0.push_back(w);
        send_bits0(w, 32, gaps);
    endtask

    task automatic idle0();
        f0 = 1'b0; v0 = 1'b0; b0 = 1'b0;
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        f0 = 0; v0 = 0; b0 = 0; f1 = 0; v1 = 0; b1 = 0;
        step(); step();
        check("rst_word", word0, 32'h0);
        check("rst_wren", 32'(wren0), 32'h0);
        check("rst_busy", 32'(busy0), 32'h0);
        check("rst_cnt", 32'(cnt0), 32'h0);
        rst_n = 1'b1;
        step();

        // 1: single word, latency one cycle after the last bit
        send_word0(32'hA5C30F17, 1'b0);
        check("t1_wren", 32'(wren0), 32'h1);
        check("t1_word", word0, 32'hA5C30F17);
        check("t1_ferr", 32'(ferr0), 32'h0);
        idle0();
        check("t1_clean_end_ferr", 32'(ferr0), 32'h0);
        check("t1_busy", 32'(busy0), 32'h0);

        // 2: back-to-back words in one frame
        send_word0(32'h00000001, 1'b0);
        send_word0(32'hFFFFFFFF, 1'b0);
        check("t2_busy", 32'(busy0), 32'h1);
        idle0();
        check("t2_spacing", 32'(last_wren_cyc - prev_wren_cyc), 32'd32);
        check("t2_wren_cnt", 32'(wren_cnt0), 32'd3);

        // 3: 17 bits then frame drop
        send_bits0(32'h12345678, 17, 1'b0);
        check("t3_cnt17", 32'(cnt0), 32'd17);
        check("t3_busy", 32'(busy0), 32'h1);
        idle0();
        check("t3_ferr", 32'(ferr0), 32'h1);
        check("t3_wren", 32'(wren0), 32'h0);
        check("t3_word_held", word0, 32'hFFFFFFFF);
        check("t3_busy_after", 32'(busy0), 32'h0);
        check("t3_cnt_after", 32'(cnt0), 32'h0);
        idle0();
        check("t3_ferr_one_cycle", 32'(ferr0), 32'h0);

        // 3b: frame low on the would-be 32nd bit aborts
        send_bits0(32'hCAFEF00D, 31, 1'b0);
        check("t3b_cnt31", 32'(cnt0), 32'd31);
        f0 = 1'b0; v0 = 1'b1; b0 = 1'b1;
        step();
        check("t3b_ferr", 32'(ferr0), 32'h1);
        check("t3b_wren", 32'(wren0), 32'h0);
        idle0();
        check("t3b_ferr_cnt", 32'(ferr_cnt0), 32'd2);

        // 4: bit_valid toggling outside a frame is ignored
        for (int i = 0; i < 40; i++) begin
            f0 = 1'b0; v0 = i[0]; b0 = i[1];
            step();
        end
        check("t4_cnt", 32'(cnt0), 32'h0);
        check("t4_busy", 32'(busy0), 32'h0);
        check("t4_ferr_cnt", 32'(ferr_cnt0), 32'd2);
        check("t4_wren_cnt", 32'(wren_cnt0), 32'd3);
        send_word0(32'h5A5A5A5A, 1'b1);
        idle0();
        check("t4_gap_word", word0, 32'h5A5A5A5A);

        // 5: reset mid-word, then a clean word
        send_bits0(32'h0F0F0F0F, 10, 1'b0);
        rst_n = 1'b0; f0 = 1'b0;
        step();
        check("t5_rst_word", word0, 32'h0);
        check("t5_rst_cnt", 32'(cnt0), 32'h0);
        check("t5_rst_busy", 32'(busy0), 32'h0);
        check("t5_rst_ferr", 32'(ferr0), 32'h0);
        rst_n = 1'b1;
        send_word0(32'hDEADBEEF, 1'b0);
        check("t5_wren", 32'(wren0), 32'h1);
        idle0();
        check("t5_word", word0, 32'hDEADBEEF);
        check("t5_wren_cnt", 32'(wren_cnt0), 32'd5);
        check("t5_ferr_cnt", 32'(ferr_cnt0), 32'd2);

        // 6: LSB-first instance
        exp_q1.push_back(32'h12345678);
        for (int i = 0; i < 32; i++) begin
            f1 = 1'b1; v1 = 1'b1; b1 = exp_q1[0][i];
            step();
        end
        f1 = 1'b0; v1 = 1'b0;
        check("t6_wren", 32'(wren1), 32'h1);
        step();
        check("t6_word", word1, 32'h12345678);
        check("t6_ferr", 32'(ferr1), 32'h0);
        check("t6_wren_cnt", 32'(wren_cnt1), 32'd1);

        step();
        check("q0_empty", 32'(exp_q0.size()), 32'h0);
        check("q1_empty", 32'(exp_q1.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
